// File: rtl/truth_table_checker.sv
// Exhaustive equivalence checker for two M-output combinational forms.
// Drives every N-bit vector, lets it settle, compares f_a/f_b, records the result.
module truth_table_checker #(
  parameter int N          = 4,
  parameter int M          = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] vec,
  input  logic [M-1:0] f_a,
  input  logic [M-1:0] f_b,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [N-1:0] VEC_MAX  = '1;
  localparam logic [7:0]   CNT_LAST = 8'(SETTLE_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       mis;
  logic [N:0] err_inc;

  assign mis     = (f_a != f_b);
  assign err_inc = err_count + {{N{1'b0}}, mis};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= SETTLE;
            vec             <= '0;
            cnt             <= '0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_count <= err_inc;
          if (mis && !first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
          end
          // pass uses the post-increment count so the final vector counts
          if (vec == VEC_MAX) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_inc == '0);
          end else begin
            vec   <= vec + 1'b1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checker instances (N=4/M=2/S=2 and N=3/M=1/S=1).
// Functions under test are modelled here as minterm tables vs. reduced logic.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n;

  logic       start4;
  logic [3:0] vec4;
  logic [1:0] fa4, fb4;
  logic       busy4, done4, pass4, fev4_v;
  logic [4:0] err4;
  logic [3:0] fev4;

  logic       start3;
  logic [2:0] vec3;
  logic [0:0] fa3, fb3;
  logic       busy3, done3, pass3, fev3_v;
  logic [3:0] err3;
  logic [2:0] fev3;

  int mode = 0;
  int n_chk = 0;
  int n_fail = 0;

  // Y = AB + CD, Z = B'D + AC' (vec = ABCD); F2 = x'y + xz (vec = xyz)
  logic [15:0] y_mt  = 16'hF888;
  logic [15:0] z_mt  = 16'h3B0A;
  logic [7:0]  f2_mt = 8'hAC;

  always #5 clk = ~clk;

  always_comb begin
    fa4 = {y_mt[vec4], z_mt[vec4]};
    fb4[1] = (vec4[3] & vec4[2]) | (vec4[1] & vec4[0]);
    fb4[0] = (~vec4[2] & vec4[0]) | (vec4[3] & ~vec4[1]);
    if (mode == 1 && (vec4 == 4'd5 || vec4 == 4'd12)) fb4[0] = ~fb4[0];
    if (mode == 2) fb4 = ~fa4;
  end

  always_comb begin
    fa3[0] = f2_mt[vec3];
    fb3[0] = (~vec3[2] & vec3[1]) | (vec3[2] & vec3[0]);
  end

  truth_table_checker #(.N(4), .M(2), .SETTLE_CYC(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .vec(vec4),
    .f_a(fa4), .f_b(fb4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_err_vec(fev4), .first_err_valid(fev4_v)
  );

  truth_table_checker #(.N(3), .M(1), .SETTLE_CYC(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .vec(vec3),
    .f_a(fa3), .f_b(fb3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_vec(fev3), .first_err_valid(fev3_v)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run4(input int extra, output int cyc, output int nd);
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    check("busy4_after_start", int'(busy4), 1);
    cyc = 0;
    nd  = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        nd++;
        if (cyc == 0) cyc = i;
      end
      start4 = (i == extra - 1);
    end
    start4 = 1'b0;
  endtask

  task automatic run3(output int cyc, output int nd);
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    cyc = 0;
    nd  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done3) begin
        nd++;
        if (cyc == 0) cyc = i;
      end
    end
  endtask

  initial begin
    int cyc, nd, got;
    rst_n  = 1'b0;
    start4 = 1'b0;
    start3 = 1'b0;
    #12;
    check("rst_busy", int'(busy4), 0);
    check("rst_vec", int'(vec4), 0);
    check("rst_err", int'(err4), 0);
    check("rst_pass", int'(pass4), 0);
    check("rst_done", int'(done4), 0);
    check("rst_fev", int'(fev4), 0);
    check("rst_fev_valid", int'(fev4_v), 0);
    check("rst_vec3", int'(vec3), 0);
    @(negedge clk) rst_n = 1'b1;

    mode = 0;
    run4(0, cyc, nd);
    check("eq_done_cycle", cyc, 48);
    check("eq_done_pulses", nd, 1);
    check("eq_pass", int'(pass4), 1);
    check("eq_err", int'(err4), 0);
    check("eq_fev_valid", int'(fev4_v), 0);
    check("eq_vec_hold", int'(vec4), 15);
    check("eq_busy_idle", int'(busy4), 0);

    mode = 1;
    run4(0, cyc, nd);
    check("inj_done_cycle", cyc, 48);
    check("inj_err", int'(err4), 2);
    check("inj_fev", int'(fev4), 5);
    check("inj_fev_valid", int'(fev4_v), 1);
    check("inj_pass", int'(pass4), 0);

    mode = 2;
    run4(0, cyc, nd);
    check("all_err", int'(err4), 16);
    check("all_fev", int'(fev4), 0);
    check("all_fev_valid", int'(fev4_v), 1);
    check("all_pass", int'(pass4), 0);

    run3(cyc, nd);
    check("n3_done_cycle", cyc, 16);
    check("n3_done_pulses", nd, 1);
    check("n3_pass", int'(pass3), 1);
    check("n3_err", int'(err3), 0);
    check("n3_vec_hold", int'(vec3), 7);

    mode = 0;
    run4(10, cyc, nd);
    check("restart_done_cycle", cyc, 48);
    check("restart_done_pulses", nd, 1);
    check("restart_pass", int'(pass4), 1);
    repeat (5) @(posedge clk);
    #1;
    check("persist_pass", int'(pass4), 1);
    check("persist_vec", int'(vec4), 15);

    mode = 2;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (vec4 == 4'd6) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mid_vec6_reached", got, 1);
    check("mid_err_nonzero", int'(err4 != 5'd0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy4), 0);
    check("mid_rst_vec", int'(vec4), 0);
    check("mid_rst_err", int'(err4), 0);
    check("mid_rst_fev_valid", int'(fev4_v), 0);
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    run4(0, cyc, nd);
    check("post_rst_done_cycle", cyc, 48);
    check("post_rst_pass", int'(pass4), 1);
    check("post_rst_err", int'(err4), 0);
    check("post_rst_fev_valid", int'(fev4_v), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential stimulus/response block that closes the loop around a combinational N-input logic function under test.
- Sweeps every input vector 0..2^N-1 on `vec` and waits a settling time. It then reads back two M-bit implementations of the same function (canonical sum-of-products vs. simplified form) and compares them.
- Reports pass/fail, a mismatch count and the first failing vector.
- Sits in the lab/test harness as the "reader" side of the course's combinational exercises, so two gate-level forms can be proven equivalent on hardware.

Parameters:
- N, 4, width of the input vector driven to the function under test (2^N vectors swept).
- M, 2, number of function outputs compared per vector.
- SETTLE_CYC, 2, clock cycles `vec` is held stable before sampling; legal range 1..255.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a sweep; sampled only in IDLE.
- vec, output, N, input vector applied to both implementations.
- f_a, input, M, outputs of implementation A (reference form).
- f_b, input, M, outputs of implementation B (simplified form).
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse when a sweep completes.
- pass, output, 1, 1 when the last completed sweep had zero mismatches; held until the next start.
- err_count, output, N+1, number of vectors with f_a != f_b in the current or last sweep.
- first_err_vec, output, N, value of `vec` at the first mismatch.
- first_err_valid, output, 1, first_err_vec holds a captured value.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0, settle counter=0. Reset takes effect immediately mid-sweep. No partial result survives.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0.
  - If start=1 at an edge, go to SETTLE and set vec=0, settle counter=0, busy=1, err_count=0, first_err_valid=0, first_err_vec=0, pass=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE_CYC-1, go to SAMPLE at the next edge.
  - vec is stable throughout.
- SAMPLE (one cycle), compare all M bits of f_a vs f_b:
  - On mismatch: err_count += 1. If first_err_valid=0, latch first_err_vec=vec and set first_err_valid=1.
  - If vec == 2^N-1, go to DONE. Otherwise vec += 1, counter=0, go to SETTLE.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0), next state IDLE.
- Cycle count per vector is SETTLE_CYC+1.
- Timing: with start captured at edge k, done is high during the cycle following edge k + 2^N·(SETTLE_CYC+1).
- err_count width N+1 holds the all-mismatch case 2^N without wrap.
- vec never wraps inside a sweep. After DONE, vec holds 2^N-1 until the next start.
- start while busy (SETTLE/SAMPLE/DONE) is ignored and does not restart the sweep.
- start asserted in the same cycle DONE exits is also ignored. A new sweep requires start while in IDLE.
- Outputs pass/err_count/first_err_* persist in IDLE until the next accepted start.
- f_a/f_b are treated as combinational responses to vec. They are only sampled in SAMPLE, never in SETTLE.

Test Plan:
- Equivalent functions, N=4, M=2, SETTLE_CYC=2:
  - Stimulus: bench models f_a={Y,Z} canonical and f_b={Y,Z} simplified over vec=ABCD, one start pulse.
  - Required: done after 48 cycles, pass=1, err_count=0, first_err_valid=0.
- Injected faults: f_b bit0 inverted only at vec=5 and vec=12.
  - Required: err_count=2, first_err_vec=5, first_err_valid=1, pass=0.
- Total mismatch: f_b=~f_a for all vectors.
  - Required: err_count=16 (no wrap), first_err_vec=0, pass=0.
- N=3, M=1, SETTLE_CYC=1, F2 canonical vs. simplified over vec=xyz.
  - Required: done 16 cycles after start, pass=1, vec=7 after completion.
- Start during sweep: second start pulse at cycle 10.
  - Required: sweep unaffected, done still at cycle 48, single done pulse.
- Reset mid-sweep: rst_n=0 asynchronously at vec=6.
  - Required: busy, vec, err_count and first_err_valid go to 0 immediately. A new start then gives a clean full sweep with correct results.
